// File: rtl/scene_controller.sv
// -----------------------------------------------------------------------------
// scene_controller
//
// Game scene sequencer and pixel colour selector. It tracks the current screen
// (title, play, pause, respawn, game over, high score), lives, score and high
// score. Each cycle it also picks the pixel colour for that screen: a
// full-screen source, or a priority composite of the play-field layers.
//
// Parameters
//   NUM_LAYERS      play-field colour layers composited (1..8)
//   LIVES_INIT      lives loaded at game start (1..15)
//   SCORE_W         score / high score width
//   RESPAWN_FRAMES  frames spent respawning after a non-fatal hit (1..255)
//   GAMEOVER_FRAMES minimum game-over frames before action is accepted (1..255)
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   action_pulse      game action (start / advance screens)
//   pause_pulse       pause toggle
//   hit_pulse         player hit
//   score_inc         add one point
//   layer_color       RRRGGGBB per layer, layer k in [8k+7:8k], layer 0 = ship
//   title_color,
//   gameover_color,
//   highscore_color   full-screen RRRGGGBB sources
//   r, g, b           registered pixel colour
//   screen            state code (TITLE=0 .. HIGH_SCORE=5)
//   lives, score,
//   high_score        game counters
//   play_active       high only in PLAY
// -----------------------------------------------------------------------------
module scene_controller #(
   parameter int unsigned NUM_LAYERS      = 4,
   parameter int unsigned LIVES_INIT      = 3,
   parameter int unsigned SCORE_W         = 10,
   parameter int unsigned RESPAWN_FRAMES  = 60,
   parameter int unsigned GAMEOVER_FRAMES = 120
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    action_pulse,
   input  logic                    pause_pulse,
   input  logic                    hit_pulse,
   input  logic                    score_inc,
   input  logic [NUM_LAYERS*8-1:0] layer_color,
   input  logic [7:0]              title_color,
   input  logic [7:0]              gameover_color,
   input  logic [7:0]              highscore_color,
   output logic [2:0]              r,
   output logic [2:0]              g,
   output logic [1:0]              b,
   output logic [2:0]              screen,
   output logic [3:0]              lives,
   output logic [SCORE_W-1:0]      score,
   output logic [SCORE_W-1:0]      high_score,
   output logic                    play_active
);

   typedef enum logic [2:0] {
      TITLE      = 3'd0,
      PLAY       = 3'd1,
      PAUSE      = 3'd2,
      RESPAWN    = 3'd3,
      GAME_OVER  = 3'd4,
      HIGH_SCORE = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [3:0]         lives_q, lives_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] hs_q, hs_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               blink_q, blink_d;
   logic               play_q, play_d;
   logic [7:0]         rgb_q, rgb_d;

   logic [SCORE_W-1:0] score_sat;
   logic [7:0]         comp;
   logic               found;
   logic               hide_ship;

   // Score including a same-cycle point, saturating at all-ones. The fatal-hit
   // high-score compare uses this so a simultaneous point is not lost.
   always_comb begin
      score_sat = score_q;
      if (score_inc && (score_q != '1)) begin
         score_sat = score_q + 1'b1;
      end
   end

   // Priority composite: lowest-index non-zero layer wins. The ship layer is
   // skipped on blink frames while respawning.
   assign hide_ship = (state_q == RESPAWN) && blink_q;

   always_comb begin
      comp  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
         if (!found && (layer_color[8*i +: 8] != 8'h00) && !((i == 0) && hide_ship)) begin
            comp  = layer_color[8*i +: 8];
            found = 1'b1;
         end
      end
   end

   // Colour source for the current screen.
   always_comb begin
      case (state_q)
         TITLE:         rgb_d = title_color;
         PLAY, RESPAWN: rgb_d = comp;
         PAUSE:         rgb_d = {1'b0, comp[7:6], 1'b0, comp[4:3], 1'b0, comp[1]};
         GAME_OVER:     rgb_d = gameover_color;
         HIGH_SCORE:    rgb_d = highscore_color;
         default:       rgb_d = '0;
      endcase
   end

   // Next-state logic for the scene FSM and its counters.
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      score_d = score_q;
      hs_d    = hs_q;
      cnt_d   = cnt_q;
      blink_d = blink_q;

      case (state_q)
         TITLE: begin
            if (action_pulse) begin
               state_d = PLAY;
               lives_d = 4'(LIVES_INIT);
               score_d = '0;
            end
         end

         PLAY: begin
            score_d = score_sat;
            if (hit_pulse) begin
               // A hit outranks a same-cycle pause; the pause is dropped.
               if (lives_q > 4'd1) begin
                  state_d = RESPAWN;
                  lives_d = lives_q - 4'd1;
                  cnt_d   = 8'(RESPAWN_FRAMES);
                  blink_d = 1'b0;
               end else begin
                  state_d = GAME_OVER;
                  lives_d = '0;
                  cnt_d   = 8'(GAMEOVER_FRAMES);
                  if (score_sat > hs_q) begin
                     hs_d = score_sat;
                  end
               end
            end else if (pause_pulse) begin
               state_d = PAUSE;
            end
         end

         PAUSE: begin
            if (pause_pulse) begin
               state_d = PLAY;
            end
         end

         RESPAWN: begin
            score_d = score_sat;
            if (frame_tick) begin
               cnt_d   = cnt_q - 8'd1;
               blink_d = ~blink_q;
               if (cnt_q <= 8'd1) begin
                  state_d = PLAY;
                  cnt_d   = '0;
                  blink_d = 1'b0;
               end
            end
         end

         GAME_OVER: begin
            if (action_pulse && (cnt_q == 8'd0)) begin
               state_d = HIGH_SCORE;
            end else if (frame_tick && (cnt_q != 8'd0)) begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         HIGH_SCORE: begin
            if (action_pulse) begin
               state_d = TITLE;
            end
         end

         default: begin
            state_d = TITLE;
         end
      endcase
   end

   assign play_d = (state_d == PLAY);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= TITLE;
         lives_q <= 4'(LIVES_INIT);
         score_q <= '0;
         hs_q    <= '0;
         cnt_q   <= '0;
         blink_q <= 1'b0;
         play_q  <= 1'b0;
         rgb_q   <= '0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         score_q <= score_d;
         hs_q    <= hs_d;
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
         play_q  <= play_d;
         rgb_q   <= rgb_d;
      end
   end

   assign r           = rgb_q[7:5];
   assign g           = rgb_q[4:2];
   assign b           = rgb_q[1:0];
   assign screen      = state_q;
   assign lives       = lives_q;
   assign score       = score_q;
   assign high_score  = hs_q;
   assign play_active = play_q;

endmodule

// File: tb/tb_scene_controller.sv
// -----------------------------------------------------------------------------
// tb_scene_controller
//
// Directed bench for scene_controller. A second instance with a 4-bit score
// shares the same stimulus to exercise score saturation.
// -----------------------------------------------------------------------------
module tb_scene_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick, action_pulse, pause_pulse, hit_pulse, score_inc;
   logic [31:0] layer_color;
   logic [7:0]  title_color, gameover_color, highscore_color;

   logic [2:0]  r, g, screen;
   logic [1:0]  b;
   logic [3:0]  lives;
   logic [9:0]  score, high_score;
   logic        play_active;

   logic [2:0]  r4, g4, screen4;
   logic [1:0]  b4;
   logic [3:0]  lives4;
   logic [3:0]  score4, high_score4;
   logic        play_active4;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   scene_controller #(
      .NUM_LAYERS     (4),
      .LIVES_INIT     (3),
      .SCORE_W        (10),
      .RESPAWN_FRAMES (60),
      .GAMEOVER_FRAMES(120)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .frame_tick     (frame_tick),
      .action_pulse   (action_pulse),
      .pause_pulse    (pause_pulse),
      .hit_pulse      (hit_pulse),
      .score_inc      (score_inc),
      .layer_color    (layer_color),
      .title_color    (title_color),
      .gameover_color (gameover_color),
      .highscore_color(highscore_color),
      .r              (r),
      .g              (g),
      .b              (b),
      .screen         (screen),
      .lives          (lives),
      .score          (score),
      .high_score     (high_score),
      .play_active    (play_active)
   );

   scene_controller #(
      .NUM_LAYERS     (4),
      .LIVES_INIT     (3),
      .SCORE_W        (4),
      .RESPAWN_FRAMES (60),
      .GAMEOVER_FRAMES(120)
   ) u_dut4 (
      .clk            (clk),
      .reset          (reset),
      .frame_tick     (frame_tick),
      .action_pulse   (action_pulse),
      .pause_pulse    (pause_pulse),
      .hit_pulse      (hit_pulse),
      .score_inc      (score_inc),
      .layer_color    (layer_color),
      .title_color    (title_color),
      .gameover_color (gameover_color),
      .highscore_color(highscore_color),
      .r              (r4),
      .g              (g4),
      .b              (b4),
      .screen         (screen4),
      .lives          (lives4),
      .score          (score4),
      .high_score     (high_score4),
      .play_active    (play_active4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle pulse on any combination of the event inputs.
   task automatic pulse(input logic a, input logic p, input logic h, input logic s, input logic t);
      action_pulse = a;
      pause_pulse  = p;
      hit_pulse    = h;
      score_inc    = s;
      frame_tick   = t;
      step();
      action_pulse = 1'b0;
      pause_pulse  = 1'b0;
      hit_pulse    = 1'b0;
      score_inc    = 1'b0;
      frame_tick   = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      reset           = 1'b1;
      frame_tick      = 1'b0;
      action_pulse    = 1'b0;
      pause_pulse     = 1'b0;
      hit_pulse       = 1'b0;
      score_inc       = 1'b0;
      title_color     = 8'hA9;          // r=5 g=2 b=1
      gameover_color  = 8'h4E;
      highscore_color = 8'h93;
      layer_color     = 32'h0000_1CE0;  // layer0=E0 (red), layer1=1C (green)

      // Reset state
      step();
      step();
      chk("rst_screen", {29'd0, screen}, 32'd0);
      chk("rst_lives", {28'd0, lives}, 32'd3);
      chk("rst_score", {22'd0, score}, 32'd0);
      chk("rst_hs", {22'd0, high_score}, 32'd0);
      chk("rst_play", {31'd0, play_active}, 32'd0);
      chk("rst_rgb", {24'd0, r, g, b}, 32'd0);
      reset = 1'b0;
      step();
      chk("title_rgb", {24'd0, r, g, b}, 32'hA9);

      // Start game
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("start_screen", {29'd0, screen}, 32'd1);
      chk("start_lives", {28'd0, lives}, 32'd3);
      chk("start_score", {22'd0, score}, 32'd0);
      chk("start_play", {31'd0, play_active}, 32'd1);
      step();
      chk("play_rgb_ship", {24'd0, r, g, b}, 32'hE0);

      // Five points then a non-fatal hit
      for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("score5", {22'd0, score}, 32'd5);
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("hit1_lives", {28'd0, lives}, 32'd2);
      chk("hit1_screen", {29'd0, screen}, 32'd3);
      chk("hit1_play", {31'd0, play_active}, 32'd0);
      step();
      chk("resp_blink0_rgb", {24'd0, r, g, b}, 32'hE0);
      ticks(1);
      step();
      chk("resp_blink1_rgb", {24'd0, r, g, b}, 32'h1C);
      pulse(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("resp_ign_lives", {28'd0, lives}, 32'd2);
      chk("resp_ign_screen", {29'd0, screen}, 32'd3);
      ticks(1);
      step();
      chk("resp_blink2_rgb", {24'd0, r, g, b}, 32'hE0);
      ticks(57);
      chk("resp_59_screen", {29'd0, screen}, 32'd3);
      ticks(1);
      chk("resp_done_screen", {29'd0, screen}, 32'd1);
      chk("resp_done_play", {31'd0, play_active}, 32'd1);

      // Second hit, then fatal hit with a same-cycle point
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("hit2_lives", {28'd0, lives}, 32'd1);
      ticks(60);
      chk("resp2_done", {29'd0, screen}, 32'd1);
      pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("go_screen", {29'd0, screen}, 32'd4);
      chk("go_lives", {28'd0, lives}, 32'd0);
      chk("go_score", {22'd0, score}, 32'd6);
      chk("go_hs", {22'd0, high_score}, 32'd6);
      step();
      chk("go_rgb", {24'd0, r, g, b}, 32'h4E);
      ticks(119);
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("go_early_action", {29'd0, screen}, 32'd4);
      ticks(1);
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hs_screen", {29'd0, screen}, 32'd5);
      step();
      chk("hs_rgb", {24'd0, r, g, b}, 32'h93);
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("back_title", {29'd0, screen}, 32'd0);
      chk("back_score", {22'd0, score}, 32'd6);
      chk("back_hs", {22'd0, high_score}, 32'd6);

      // Pause dimming and ignored inputs
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("g2_score", {22'd0, score}, 32'd0);
      chk("g2_lives", {28'd0, lives}, 32'd3);
      layer_color = 32'h0000_FF00;
      step();
      chk("g2_rgb", {24'd0, r, g, b}, 32'hFF);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("pause_screen", {29'd0, screen}, 32'd2);
      chk("pause_play", {31'd0, play_active}, 32'd0);
      step();
      chk("pause_rgb", {24'd0, r, g, b}, 32'h6D);
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("pause_hit_lives", {28'd0, lives}, 32'd3);
      chk("pause_hit_screen", {29'd0, screen}, 32'd2);
      pulse(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("pause_inc_score", {22'd0, score}, 32'd0);
      chk("pause_act_screen", {29'd0, screen}, 32'd2);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("unpause_screen", {29'd0, screen}, 32'd1);
      step();
      chk("unpause_rgb", {24'd0, r, g, b}, 32'hFF);

      // Hit and pause together: hit wins
      pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("hitpause_screen", {29'd0, screen}, 32'd3);
      chk("hitpause_lives", {28'd0, lives}, 32'd2);

      // Reset mid-respawn
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst2_screen", {29'd0, screen}, 32'd0);
      chk("rst2_lives", {28'd0, lives}, 32'd3);
      chk("rst2_hs", {22'd0, high_score}, 32'd0);
      chk("rst2_rgb", {24'd0, r, g, b}, 32'd0);

      // All layers clear, then score saturation on the narrow instance
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      layer_color = 32'h0;
      step();
      chk("blank_rgb", {24'd0, r, g, b}, 32'd0);
      for (int i = 0; i < 20; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("score20", {22'd0, score}, 32'd20);
      chk("sat_score4", {28'd0, score4}, 32'd15);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/scene_controller.md
SCENE_CONTROLLER -- requirements
Module: scene_controller

Interface
REQ-001 Parameter NUM_LAYERS, 4, number of play-screen colour layers composited (1..8).
REQ-002 Parameter LIVES_INIT, 3, lives loaded at game start (1..15).
REQ-003 Parameter SCORE_W, 10, width of score and high score.
REQ-004 Parameter RESPAWN_FRAMES, 60, frames spent in RESPAWN after a non-fatal hit (1..255).
REQ-005 Parameter GAMEOVER_FRAMES, 120, minimum frames in GAME_OVER before action is accepted (1..255).
REQ-006 clk  in  1  system clock; the only clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 action_pulse  in  1  debounced one-cycle game action.
REQ-010 pause_pulse  in  1  debounced one-cycle pause toggle.
REQ-011 hit_pulse  in  1  one-cycle "player hit" event.
REQ-012 score_inc  in  1  one-cycle "add one point" event.
REQ-013 layer_color  in  NUM_LAYERS*8  RRRGGGBB per layer; layer k in bits [8k+7:8k]; layer 0 is the ship and has highest priority.
REQ-014 title_color, gameover_color, highscore_color  in  8 each  full-screen RRRGGGBB sources.
REQ-015 r  out  3 / g  out  3 / b  out  2  registered pixel colour.
REQ-016 screen  out  3  state code: TITLE=0, PLAY=1, PAUSE=2, RESPAWN=3, GAME_OVER=4, HIGH_SCORE=5.
REQ-017 lives  out  4 / score  out  SCORE_W / high_score  out  SCORE_W.
REQ-018 play_active  out  1  high only in PLAY; enables game-object motion.

Function
REQ-019 TITLE: action_pulse -> PLAY; same edge loads lives=LIVES_INIT and score=0.
REQ-020 PLAY: score_inc adds 1 to score, saturating at 2^SCORE_W-1.
REQ-021 PLAY: hit_pulse with lives>1 -> lives-1, RESPAWN, frame counter=RESPAWN_FRAMES.
REQ-022 PLAY: hit_pulse with lives==1 -> lives=0, GAME_OVER, frame counter=GAMEOVER_FRAMES, high_score=max(high_score, final score).
REQ-023 PLAY: pause_pulse without hit_pulse -> PAUSE; when both occur in the same cycle, the hit takes precedence and the pause is dropped.
REQ-024 Simultaneous score_inc and fatal hit_pulse: the point is counted before the high_score compare.
REQ-025 PAUSE: pause_pulse -> PLAY; hit_pulse, score_inc and action_pulse are ignored.
REQ-026 RESPAWN: counter decrements on each frame_tick; the frame_tick that takes it to 0 moves the state to PLAY; hit_pulse, pause_pulse and action_pulse are ignored; score_inc is still counted.
REQ-027 RESPAWN: blink bit toggles on each frame_tick and is cleared on entry; layer 0 is suppressed while blink=1.
REQ-028 GAME_OVER: counter decrements on frame_tick and holds at 0; action_pulse is ignored while counter!=0; action_pulse with counter==0 -> HIGH_SCORE.
REQ-029 HIGH_SCORE: action_pulse -> TITLE; score and high_score hold.
REQ-030 Composite: the lowest-index layer with a non-zero colour wins; all layers zero gives 0.
REQ-031 Colour source per state: TITLE=title_color; PLAY and RESPAWN=composite; PAUSE=composite with each of r, g, b right-shifted by 1 (dimmed); GAME_OVER=gameover_color; HIGH_SCORE=highscore_color.
REQ-032 r, g and b are registered with 1-cycle latency from the colour inputs and the current state.
REQ-033 screen, lives, score, high_score and play_active are registered, and each update on the edge that changes the state.
REQ-034 Undefined state codes 6 and 7 recover to TITLE on the next clock.

Reset
REQ-035 When reset is high at a clk edge: state=TITLE, lives=LIVES_INIT, score=0, high_score=0, counter=0, blink=0, r=g=b=0, play_active=0.
REQ-036 Reset takes priority over every other input, including mid-RESPAWN and mid-GAME_OVER.

Verification
REQ-037 Reset, action_pulse -> screen=1, lives=3, score=0, play_active=1 one cycle later.
REQ-038 In PLAY, 5x score_inc, hit_pulse -> lives=2, screen=3; 60 frame_ticks -> screen=1; layer 0 blanked on alternate frames.
REQ-039 3 hits with 1 pending score_inc on the last hit (score 6) -> screen=4, high_score=6; action_pulse before 120 frame_ticks ignored; action_pulse after -> 5; next action_pulse -> 0.
REQ-040 PAUSE with layer0=0x00, layer1=0xFF -> rgb=3,3,1; hit_pulse ignored; pause_pulse -> PLAY, rgb=7,7,3.
REQ-041 hit_pulse and pause_pulse in the same cycle in PLAY -> screen=3, no PAUSE.
REQ-042 score saturation with SCORE_W=4: 20 score_inc -> score=15.
